// File: rtl/serv_imm_serdes.sv
// Instruction-field latch and immediate serializer: captures an ibus word, decodes its
// RISC-V immediate, then streams it (and the CSR zimm) LSB-first, W bits per beat.
module serv_imm_serdes #(
  parameter int W        = 1,
  parameter int WITH_CSR = 1
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_wb_en,
  input  logic [31:0]  i_wb_rdt,
  input  logic         i_cnt_en,
  output logic [W-1:0] o_imm,
  output logic [W-1:0] o_csr_imm,
  output logic         o_cnt_done,
  output logic         o_busy,
  output logic [4:0]   o_rf_rd_addr,
  output logic [4:0]   o_rf_rs1_addr,
  output logic [4:0]   o_rf_rs2_addr,
  output logic [4:0]   o_opcode,
  output logic [2:0]   o_funct3
);

  localparam int BEATS = 32 / W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ZW    = (W > 5) ? W : 5;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  function automatic logic signed [31:0] decode_imm(input logic [31:0] inst);
    logic s;
    s = inst[31];
    case (inst[6:2])
      5'b01101, 5'b00101:                   decode_imm = {inst[31:12], 12'b0};
      5'b11011:                             decode_imm = {{12{s}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      5'b11000:                             decode_imm = {{20{s}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      5'b01000:                             decode_imm = {{21{s}}, inst[30:25], inst[11:7]};
      5'b11001, 5'b00000, 5'b00100, 5'b11100: decode_imm = {{21{s}}, inst[30:20]};
      default:                              decode_imm = '0;
    endcase
  endfunction

  logic signed [31:0] sr_q, sr_d;
  logic [ZW-1:0]      z_q, z_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [4:0]         rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d, op_q, op_d;
  logic [2:0]         f3_q, f3_d;
  logic [ZW-1:0]      zimm_load;
  logic               unused_rdt;

  // The opcode's low two bits are always 2'b11 for 32-bit encodings.
  assign unused_rdt = ^i_wb_rdt[1:0];

  assign zimm_load = (WITH_CSR != 0 && i_wb_rdt[14]) ? ZW'(i_wb_rdt[19:15]) : '0;

  always_comb begin
    sr_d   = sr_q;
    z_d    = z_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    rd_d   = rd_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    op_d   = op_q;
    f3_d   = f3_q;
    // A load takes priority over any beat, including one for an in-flight stream.
    if (i_wb_en) begin
      sr_d   = decode_imm(i_wb_rdt);
      z_d    = zimm_load;
      cnt_d  = '0;
      busy_d = 1'b1;
      rd_d   = i_wb_rdt[11:7];
      rs1_d  = i_wb_rdt[19:15];
      rs2_d  = i_wb_rdt[24:20];
      op_d   = i_wb_rdt[6:2];
      f3_d   = i_wb_rdt[14:12];
    end else if (i_cnt_en && busy_q) begin
      sr_d = sr_q >>> W;
      z_d  = z_q >> W;
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      sr_q   <= '0;
      z_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      op_q   <= '0;
      f3_q   <= '0;
    end else begin
      sr_q   <= sr_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      rd_q   <= rd_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      op_q   <= op_d;
      f3_q   <= f3_d;
    end
  end

  assign o_imm         = sr_q[W-1:0];
  assign o_csr_imm     = z_q[W-1:0];
  assign o_busy        = busy_q;
  assign o_cnt_done    = busy_q && (cnt_q == LAST);
  assign o_rf_rd_addr  = rd_q;
  assign o_rf_rs1_addr = rs1_q;
  assign o_rf_rs2_addr = rs2_q;
  assign o_opcode      = op_q;
  assign o_funct3      = f3_q;

endmodule

// File: tb/tb_serv_imm_serdes.sv
// Scoreboard bench for serv_imm_serdes: five instances (W=1,2,4,8 with CSR, W=1 without)
// share one stimulus stream; each has its own expectation queue and monitor.
module tb_serv_imm_serdes;

  localparam int NI = 5;

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] z;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  op;
    logic [2:0]  f3;
  } exp_t;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        wb_en  = 1'b0;
  logic        cnt_en = 1'b0;
  logic [31:0] wb_rdt = '0;

  int n_vec = 0;
  int n_bad = 0;

  exp_t exp_q[NI][$];

  always #5 clk = ~clk;

  function automatic int w_of(input int g);
    return (g == 4) ? 1 : (1 << g);
  endfunction

  function automatic bit csr_of(input int g);
    return g != 4;
  endfunction

  // Immediate built arithmetically from the ISA bit positions.
  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    logic [31:0] hi;
    logic [4:0]  op;
    hi = i[31] ? 32'hFFFF_FFFF : 32'h0;
    op = i[6:2];
    if (op == 5'h0D || op == 5'h05)
      return i & 32'hFFFF_F000;
    else if (op == 5'h1B)
      return (hi << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
    else if (op == 5'h18)
      return (hi << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
    else if (op == 5'h08)
      return (hi << 11) | (32'(i[30:25]) << 5) | 32'(i[11:7]);
    else if (op == 5'h19 || op == 5'h00 || op == 5'h04 || op == 5'h1C)
      return (hi << 11) | 32'(i[30:20]);
    else
      return 32'h0;
  endfunction

  task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL u%0d %s @%0t: got %h expected %h", g, nm, $time, act, exp);
    end
  endtask

  task automatic push_all(input logic [31:0] inst);
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      e.imm = ref_imm(inst);
      e.z   = (csr_of(k) && inst[14]) ? 32'(inst[19:15]) : 32'h0;
      e.rd  = inst[11:7];
      e.rs1 = inst[19:15];
      e.rs2 = inst[24:20];
      e.op  = inst[6:2];
      e.f3  = inst[14:12];
      exp_q[k].push_back(e);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int GW = w_of(g);
    localparam int GN = 32 / GW;

    logic [GW-1:0] imm, cimm;
    logic          done, busy;
    logic [4:0]    rd, rs1, rs2, op;
    logic [2:0]    f3;

    serv_imm_serdes #(.W(GW), .WITH_CSR(g == 4 ? 0 : 1)) dut (
      .clk          (clk),
      .i_rst        (rst),
      .i_wb_en      (wb_en),
      .i_wb_rdt     (wb_rdt),
      .i_cnt_en     (cnt_en),
      .o_imm        (imm),
      .o_csr_imm    (cimm),
      .o_cnt_done   (done),
      .o_busy       (busy),
      .o_rf_rd_addr (rd),
      .o_rf_rs1_addr(rs1),
      .o_rf_rs2_addr(rs2),
      .o_opcode     (op),
      .o_funct3     (f3)
    );

    exp_t               cur = '0;
    int                 sh  = 0;
    bit                 bz  = 1'b0;
    logic signed [63:0] sx;
    logic [63:0]        zx;

    always @(negedge clk) begin
      if (rst) begin
        cur = '0;
        sh  = 0;
        bz  = 1'b0;
      end
      sx = $signed({{32{cur.imm[31]}}, cur.imm}) >>> (sh * GW);
      zx = {32'h0, cur.z} >> (sh * GW);
      chk(g, "imm",  32'(imm),  32'(sx[GW-1:0]));
      chk(g, "csr",  32'(cimm), 32'(zx[GW-1:0]));
      chk(g, "busy", 32'(busy), 32'(bz));
      chk(g, "done", 32'(done), (bz && sh == GN - 1) ? 32'd1 : 32'd0);
      chk(g, "rd",   32'(rd),   32'(cur.rd));
      chk(g, "rs1",  32'(rs1),  32'(cur.rs1));
      chk(g, "rs2",  32'(rs2),  32'(cur.rs2));
      chk(g, "op",   32'(op),   32'(cur.op));
      chk(g, "f3",   32'(f3),   32'(cur.f3));
      if (!rst) begin
        if (wb_en) begin
          if (exp_q[g].size() == 0) begin
            chk(g, "qunderflow", 32'd1, 32'd0);
          end else begin
            cur = exp_q[g].pop_front();
          end
          sh = 0;
          bz = 1'b1;
        end else if (cnt_en && bz) begin
          sh++;
          if (sh == GN) bz = 1'b0;
        end
      end
    end
  end

  task automatic load(input logic [31:0] inst, input bit ce);
    @(posedge clk); #1;
    wb_en  = 1'b1;
    wb_rdt = inst;
    cnt_en = ce;
    push_all(inst);
  endtask

  task automatic run(input int n, input bit ce);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      wb_en  = 1'b0;
      wb_rdt = $urandom;
      cnt_en = ce;
    end
  endtask

  task automatic run_rand(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      wb_en  = 1'b0;
      wb_rdt = $urandom;
      cnt_en = ($urandom_range(3) != 0);
    end
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1;
    rst    = 1'b1;
    wb_en  = 1'b0;
    cnt_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  ops[11];
    logic [31:0] r;
    ops = '{5'h0D, 5'h05, 5'h1B, 5'h18, 5'h08, 5'h19, 5'h00, 5'h04, 5'h1C, 5'h0C, 5'h03};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run(2, 1'b1);

    load(32'hFFF0_0093, 1'b0); run(34, 1'b1);   // addi x1,x0,-1
    load(32'h7E20_AE23, 1'b0); run(10, 1'b1);   // sw x2,2044(x1)
    load(32'hFE00_0EE3, 1'b0); run(18, 1'b1);   // beq x0,x0,-4
    load(32'h1234_52B7, 1'b0); run(6, 1'b1);    // lui x5,0x12345
    load(32'h3401_5073, 1'b0); run(34, 1'b1);   // csrrwi x0,mscratch,2

    // Reset mid-stream, beats ignored until reload, then load+beat together.
    load(32'h7E20_AE23, 1'b0); run(3, 1'b1);
    pulse_rst();
    run(3, 1'b1);
    load(32'h7E20_AE23, 1'b1); run(36, 1'b1);

    // Abort an in-flight stream with a new load.
    load(32'hFFF0_0093, 1'b0); run(5, 1'b1);
    load(32'h1234_52B7, 1'b0); run(36, 1'b1);

    for (int t = 0; t < 150; t++) begin
      r = $urandom;
      r[6:2] = ops[$urandom_range(10)];
      r[1:0] = 2'b11;
      load(r, bit'($urandom_range(1)));
      if ($urandom_range(19) == 0) begin
        run_rand($urandom_range(10));
        pulse_rst();
      end
      run_rand($urandom_range(45));
    end

    run(3, 1'b0);
    for (int k = 0; k < NI; k++) chk(k, "qempty", 32'(exp_q[k].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
